// File: rtl/button_gesture_pkg.sv
// Shared types and constants for the button gesture classifier.
package button_gesture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT2,
    PRESS2,
    LONG
  } state_t;

  localparam int MS_PER_S = 1000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_gesture_ms_tick.sv
// Millisecond prescaler: o_tick is high for the last cycle of every TICK_DIV-cycle
// period; i_clr restarts the period so the next tick lands TICK_DIV cycles later.
module ms_tick #(
  parameter int TICK_DIV = 100_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = (r_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/button_gesture.sv
// Click / double-click / long-press classifier fed by debounced press/release pulses.
// Optional auto-repeat while held is enabled by defining BUTTON_GESTURE_REPEAT_EN.
module button_gesture
  import button_gesture_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int LONG_MS   = 500,
  parameter int DBL_MS    = 250,
  parameter int REPEAT_MS = 100
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   btn_dn,
  input  logic   btn_up,
  output logic   click,
  output logic   dbl_click,
  output logic   long_press,
  output logic   held,
  output logic   repeat_tick,
  output state_t dbg_state
);

  localparam int TICK_DIV = CLK_HZ / MS_PER_S;
  localparam int MS_MAX   = max3(LONG_MS, DBL_MS, REPEAT_MS);
  localparam int MS_W     = $clog2(MS_MAX + 1);

  // A timeout fires on the tick that would bring the ms count up to the limit,
  // so the registered event appears exactly N*TICK_DIV cycles after state entry.
  localparam logic [MS_W-1:0] LONG_LAST = MS_W'(LONG_MS - 1);
  localparam logic [MS_W-1:0] DBL_LAST  = MS_W'(DBL_MS - 1);

  state_t          r_state;
  logic [MS_W-1:0] r_ms;

  logic w_tick;
  logic w_dn;
  logic w_up;
  logic w_long_hit;
  logic w_dbl_hit;
  logic w_change;

  // Press and release in the same cycle cancel each other out.
  assign w_dn       = btn_dn & ~btn_up;
  assign w_up       = btn_up & ~btn_dn;
  assign w_long_hit = w_tick && (r_ms == LONG_LAST);
  assign w_dbl_hit  = w_tick && (r_ms == DBL_LAST);
  assign dbg_state  = r_state;

  ms_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_ms_tick (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_change),
    .o_tick(w_tick)
  );

  // Any state change restarts both the prescaler and the ms count.
  always_comb begin
    w_change = 1'b0;
    case (r_state)
      IDLE:           w_change = w_dn;
      PRESS1, PRESS2: w_change = w_up | w_long_hit;
      WAIT2:          w_change = w_dn | w_dbl_hit;
      LONG:           w_change = w_up;
      default:        w_change = 1'b1;
    endcase
  end

`ifdef BUTTON_GESTURE_REPEAT_EN
  localparam logic [MS_W-1:0] REP_LAST = MS_W'(REPEAT_MS - 1);

  logic w_rep_hit;

  assign w_rep_hit = w_tick && (r_ms == REP_LAST);
`else
  assign repeat_tick = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ms        <= '0;
      click       <= 1'b0;
      dbl_click   <= 1'b0;
      long_press  <= 1'b0;
      held        <= 1'b0;
`ifdef BUTTON_GESTURE_REPEAT_EN
      repeat_tick <= 1'b0;
`endif
    end else begin
      click      <= 1'b0;
      dbl_click  <= 1'b0;
      long_press <= 1'b0;
`ifdef BUTTON_GESTURE_REPEAT_EN
      repeat_tick <= 1'b0;
`endif

      if (w_change) begin
        r_ms <= '0;
      end else if (w_tick && (r_ms != '1)) begin
        r_ms <= r_ms + 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_dn) r_state <= PRESS1;
        end
        PRESS1: begin
          if (w_up) begin
            r_state <= WAIT2;
          end else if (w_long_hit) begin
            r_state    <= LONG;
            long_press <= 1'b1;
            held       <= 1'b1;
          end
        end
        WAIT2: begin
          if (w_dn) begin
            r_state <= PRESS2;
          end else if (w_dbl_hit) begin
            r_state <= IDLE;
            click   <= 1'b1;
          end
        end
        PRESS2: begin
          if (w_up) begin
            r_state   <= IDLE;
            dbl_click <= 1'b1;
          end else if (w_long_hit) begin
            // The first press already completed a click before the hold began.
            r_state    <= LONG;
            click      <= 1'b1;
            long_press <= 1'b1;
            held       <= 1'b1;
          end
        end
        LONG: begin
          if (w_up) begin
            r_state <= IDLE;
            held    <= 1'b0;
          end
`ifdef BUTTON_GESTURE_REPEAT_EN
          else if (w_rep_hit) begin
            r_ms        <= '0;
            repeat_tick <= 1'b1;
          end
`endif
        end
        default: begin
          r_state <= IDLE;
          held    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_gesture.sv
// Bench for button_gesture at 10 cycles/ms: elapsed-time reference model checked
// every cycle, plus hand-computed event times for each directed gesture.
module tb_button_gesture;
  import button_gesture_pkg::*;

  localparam int CLK_HZ    = 10_000;
  localparam int LONG_MS   = 5;
  localparam int DBL_MS    = 3;
  localparam int REPEAT_MS = 2;
  localparam int TD        = CLK_HZ / 1000;
`ifdef BUTTON_GESTURE_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   btn_dn = 1'b0;
  logic   btn_up = 1'b0;
  logic   click, dbl_click, long_press, held, repeat_tick;
  state_t dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int base  = 0;

  button_gesture #(
    .CLK_HZ   (CLK_HZ),
    .LONG_MS  (LONG_MS),
    .DBL_MS   (DBL_MS),
    .REPEAT_MS(REPEAT_MS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_dn     (btn_dn),
    .btn_up     (btn_up),
    .click      (click),
    .dbl_click  (dbl_click),
    .long_press (long_press),
    .held       (held),
    .repeat_tick(repeat_tick),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  // Phase plus cycles spent in it; events are due after whole-ms multiples of TD.
  localparam int PH_IDLE = 0, PH_P1 = 1, PH_W2 = 2, PH_P2 = 3, PH_LONG = 4;
  int         m_ph = PH_IDLE;
  int         m_el = 0;
  logic [4:0] m_e;            // {repeat_tick, held, long_press, dbl_click, click}
  logic       m_dn, m_up;
  logic [4:0] exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph = PH_IDLE;
      m_el = 0;
      exp_q.delete();
    end else begin
      m_e  = '0;
      m_dn = btn_dn && !btn_up;
      m_up = btn_up && !btn_dn;
      m_el = m_el + 1;
      case (m_ph)
        PH_IDLE: if (m_dn) begin m_ph = PH_P1; m_el = 0; end
        PH_P1: begin
          if (m_up) begin m_ph = PH_W2; m_el = 0; end
          else if (m_el == LONG_MS * TD) begin m_ph = PH_LONG; m_el = 0; m_e[2] = 1'b1; end
        end
        PH_W2: begin
          if (m_dn) begin m_ph = PH_P2; m_el = 0; end
          else if (m_el == DBL_MS * TD) begin m_ph = PH_IDLE; m_el = 0; m_e[0] = 1'b1; end
        end
        PH_P2: begin
          if (m_up) begin m_ph = PH_IDLE; m_el = 0; m_e[1] = 1'b1; end
          else if (m_el == LONG_MS * TD) begin
            m_ph = PH_LONG; m_el = 0; m_e[0] = 1'b1; m_e[2] = 1'b1;
          end
        end
        default: begin
          if (m_up) begin m_ph = PH_IDLE; m_el = 0; end
          else if (REP_EN && m_el == REPEAT_MS * TD) begin m_el = 0; m_e[4] = 1'b1; end
        end
      endcase
      m_e[3] = (m_ph == PH_LONG);
      exp_q.push_back(m_e);
    end
  end

  // ---------------- scoreboard: every-cycle compare ----------------
  logic [4:0] sb_act, sb_exp;
  always @(negedge clk) begin
    sb_act = {repeat_tick, held, long_press, dbl_click, click};
    n_cmp++;
    if (rst) begin
      exp_q.delete();
      if (sb_act !== 5'b0) begin
        n_err++;
        $display("FAIL reset_outputs @%0d: got %b expected 00000", cyc, sb_act);
      end
    end else if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL model_queue_empty @%0d: got %b expected a queued value", cyc, sb_act);
    end else begin
      sb_exp = exp_q.pop_front();
      if (sb_act !== sb_exp) begin
        n_err++;
        $display("FAIL cycle_outputs @%0d (rel %0d): got %b expected %b {rep,held,long,dbl,click}",
                 cyc, cyc - base, sb_act, sb_exp);
      end
    end
  end

  // ---------------- event monitor for literal checks ----------------
  int n_click, n_dbl, n_long, n_rep, n_held;
  int f_click, f_dbl, f_long, f_rep, f_held, l_held;

  task automatic mon_clear();
    n_click = 0; n_dbl = 0; n_long = 0; n_rep = 0; n_held = 0;
    f_click = -1; f_dbl = -1; f_long = -1; f_rep = -1; f_held = -1; l_held = -1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (click)       begin n_click++; if (f_click < 0) f_click = cyc - base; end
      if (dbl_click)   begin n_dbl++;   if (f_dbl   < 0) f_dbl   = cyc - base; end
      if (long_press)  begin n_long++;  if (f_long  < 0) f_long  = cyc - base; end
      if (repeat_tick) begin n_rep++;   if (f_rep   < 0) f_rep   = cyc - base; end
      if (held) begin
        n_held++;
        if (f_held < 0) f_held = cyc - base;
        l_held = cyc - base;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Cycle 0 is the cycle in which the first pulse is presented; -1 marks unused slots.
  task automatic run_seq(input int n, input int d0, input int d1, input int u0, input int u1);
    @(negedge clk);
    base = cyc;
    mon_clear();
    for (int r = 0; r < n; r++) begin
      btn_dn = (r == d0) || (r == d1);
      btn_up = (r == u0) || (r == u1);
      @(negedge clk);
    end
    btn_dn = 1'b0;
    btn_up = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    mon_clear();
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);

    // single click: WAIT2 entered at 21, expires 30 cycles later
    run_seq(80, 0, -1, 20, -1);
    chk("t1_click_count", n_click, 1);
    chk("t1_click_time", f_click, 51);
    chk("t1_dbl_count", n_dbl, 0);
    chk("t1_long_count", n_long, 0);

    // double click
    run_seq(100, 0, 40, 20, 60);
    chk("t2_dbl_time", f_dbl, 61);
    chk("t2_dbl_count", n_dbl, 1);
    chk("t2_click_count", n_click, 0);
    chk("t2_long_count", n_long, 0);

    // long press held until release at 100
    run_seq(130, 0, -1, 100, -1);
    chk("t3_long_time", f_long, 51);
    chk("t3_long_count", n_long, 1);
    chk("t3_held_first", f_held, 51);
    chk("t3_held_last", l_held, 100);
    chk("t3_held_cycles", n_held, 50);
    chk("t3_click_count", n_click, 0);
    chk("t3_rep_count", n_rep, REP_EN ? 2 : 0);
    chk("t3_rep_first", f_rep, REP_EN ? 71 : -1);

    // click then long hold; release coincides with the first repeat due time
    run_seq(120, 0, 20, 10, 90);
    chk("t4_click_time", f_click, 71);
    chk("t4_long_time", f_long, 71);
    chk("t4_held_cycles", n_held, 20);
    chk("t4_rep_count", n_rep, 0);
    chk("t4_dbl_count", n_dbl, 0);

    // second press on the exact WAIT2 timeout cycle wins over the timeout
    run_seq(100, 0, 50, 20, 60);
    chk("t7_dbl_time", f_dbl, 61);
    chk("t7_click_count", n_click, 0);

    // stray release and simultaneous press+release in IDLE do nothing
    run_seq(60, 10, -1, 5, 10);
    chk("t6_events", n_click + n_dbl + n_long + n_rep + n_held, 0);
    run_seq(80, 0, -1, 20, -1);
    chk("t6_after_click_time", f_click, 51);
    chk("t6_after_click_count", n_click, 1);

    // async reset while held: outputs drop without waiting for a clock edge
    run_seq(61, 0, -1, -1, -1);
    chk("t5_held_before_rst", held, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("t5_outputs_in_rst", {27'd0, repeat_tick, held, long_press, dbl_click, click}, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    run_seq(100, -1, -1, 20, -1);
    chk("t5_events_after_rst", n_click + n_dbl + n_long + n_rep + n_held, 0);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
